// File: rtl/izigzag_pkg.sv
// Shared types and constants for the izigzag stream arbiter.
// Holds the FSM encoding and round-robin index helpers.
package izigzag_pkg;

    localparam int TOKEN_W   = 16;
    localparam int BLOCK_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_EOS_OUT = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    function automatic int rr_wrap(input int v, input int n);
        return v % n;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return rr_wrap(idx + 1, n);
    endfunction

endpackage

// File: rtl/izigzag_stream_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr.
// Lowest distance from ptr wins; hit_o is low when nobody requests.
module stream_rr_pick
    import izigzag_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          hit_o,
    output logic [PW-1:0] idx_o
);

    // Walk from the farthest candidate down so the nearest one lands last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[rr_wrap(int'(ptr_i) + k, N)]) begin
                hit_o = 1'b1;
                idx_o = PW'(rr_wrap(int'(ptr_i) + k, N));
            end
        end
    end

endmodule

// File: rtl/izigzag_stream_arbiter.sv
// Block-granular round-robin merge of N producer token streams
// into the izigzag page input queue, with a single merged eos.
module izigzag_stream_arbiter #(
    parameter int N_IN      = 2,
    parameter int W         = izigzag_pkg::TOKEN_W,
    parameter int BLOCK_LEN = izigzag_pkg::BLOCK_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_IN*W-1:0] in_d,
    input  logic [N_IN-1:0]   in_e,
    input  logic [N_IN-1:0]   in_v,
    output logic [N_IN-1:0]   in_b,
    output logic [W-1:0]      out_d,
    output logic              out_e,
    output logic              out_v,
    input  logic              out_b,
    output logic              done,
    output logic              err
);

    import izigzag_pkg::*;

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = $clog2(BLOCK_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_LEN - 1);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] retired_q, retired_d;
    logic            err_q, err_d;

    logic            pick_hit;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   nxt_ptr;
    logic            g_v;
    logic            g_e;
    logic [W-1:0]    g_d;

    stream_rr_pick #(
        .N  (N_IN),
        .PW (PW)
    ) u_pick (
        .req_i (in_v & ~retired_q),
        .ptr_i (ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    assign nxt_ptr = PW'(rr_next(int'(grant_q), N_IN));
    assign g_v     = in_v[grant_q];
    assign g_e     = in_e[grant_q];
    assign g_d     = in_d[int'(grant_q)*W +: W];
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        err_d     = err_q;
        out_d     = '0;
        out_e     = 1'b0;
        out_v     = 1'b0;
        in_b      = '1;
        unique case (state_q)
            ST_IDLE: begin
                if (&retired_q) begin
                    state_d = ST_EOS_OUT;
                end else if (pick_hit) begin
                    grant_d = pick_idx;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (g_e) begin
                    // eos is swallowed here; only the merged one goes out
                    in_b[grant_q] = 1'b0;
                    if (g_v) begin
                        retired_d[grant_q] = 1'b1;
                        ptr_d   = nxt_ptr;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        if (cnt_q != '0) begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    out_d         = g_d;
                    out_v         = g_v;
                    in_b[grant_q] = out_b;
                    if (g_v && !out_b) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            ptr_d   = nxt_ptr;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_EOS_OUT: begin
                out_v = 1'b1;
                out_e = 1'b1;
                if (!out_b) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_izigzag_stream_arbiter.sv
// Scoreboard bench for izigzag_stream_arbiter with three producers.
// Producer queues feed the DUT; expected merged tokens feed a monitor.
module tb_izigzag_stream_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int BL = 64;
    localparam logic [16:0] EOS = 17'h10000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*W-1:0]    in_d  = '0;
    logic [N-1:0]      in_e  = '0;
    logic [N-1:0]      in_v  = '0;
    logic [N-1:0]      in_b;
    logic [W-1:0]      out_d;
    logic              out_e;
    logic              out_v;
    logic              out_b = 1'b0;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    logic [16:0] expq[$];

    always #5 clock = ~clock;

    izigzag_stream_arbiter #(
        .N_IN      (N),
        .W         (W),
        .BLOCK_LEN (BL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in_d  (in_d),
        .in_e  (in_e),
        .in_v  (in_v),
        .in_b  (in_b),
        .out_d (out_d),
        .out_e (out_e),
        .out_v (out_v),
        .out_b (out_b),
        .done  (done),
        .err   (err)
    );

    function automatic logic [16:0] tok(input int p, input int i);
        return {1'b0, 4'(p), 12'(i)};
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        in_v[0] = (q0.size() > 0);
        in_v[1] = (q1.size() > 0);
        in_v[2] = (q2.size() > 0);
        {in_e[0], in_d[0*W +: W]} = (q0.size() > 0) ? q0[0] : 17'h0;
        {in_e[1], in_d[1*W +: W]} = (q1.size() > 0) ? q1[0] : 17'h0;
        {in_e[2], in_d[2*W +: W]} = (q2.size() > 0) ? q2[0] : 17'h0;
    endtask

    task automatic prod(input int p, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            if (p == 0) q0.push_back(tok(p, i));
            else if (p == 1) q1.push_back(tok(p, i));
            else q2.push_back(tok(p, i));
        end
    endtask

    task automatic prod_eos(input int p);
        if (p == 0) q0.push_back(EOS);
        else if (p == 1) q1.push_back(EOS);
        else q2.push_back(EOS);
    endtask

    task automatic exp_blk(input int p, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            expq.push_back(tok(p, i));
        end
    endtask

    // Producer driver: pop tokens that transferred on the last edge.
    initial begin
        logic [N-1:0] xf;
        forever begin
            @(negedge clock);
            xf = in_v & ~in_b;
            @(posedge clock);
            #1;
            if (!reset) begin
                if (xf[0]) void'(q0.pop_front());
                if (xf[1]) void'(q1.pop_front());
                if (xf[2]) void'(q2.pop_front());
            end
            drive();
        end
    end

    // Monitor: compare every merged transfer against the scoreboard.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clock);
            if (!reset && out_v && !out_b) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got e=%0b d=%0h, none expected",
                             out_e, out_d);
                end else begin
                    e = expq.pop_front();
                    check("out_token", 32'({out_e, out_d}), 32'(e));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        out_b = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        expq.delete();
        in_v = '0;
        in_e = '0;
        in_d = '0;
        #1;
        check("rst_out_v", 32'(out_v), 32'd0);
        check("rst_out_e", 32'(out_e), 32'd0);
        check("rst_out_d", 32'(out_d), 32'd0);
        check("rst_in_b", 32'(in_b), 32'h7);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_left(input int left);
        int cyc = 0;
        while (expq.size() > left && cyc < 3000) begin
            @(posedge clock);
            #2;
            cyc++;
        end
        check("wait_left_timeout", 32'(expq.size() > left), 32'd0);
    endtask

    task automatic wait_end(input logic exp_err);
        int cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clock);
            #2;
            cyc++;
        end
        check("done", 32'(done), 32'd1);
        check("err", 32'(err), 32'(exp_err));
        check("exp_left", 32'(expq.size()), 32'd0);
        @(negedge clock);
        check("post_done_out_v", 32'(out_v), 32'd0);
    endtask

    initial begin
        // 1: single producer block then eos
        do_reset();
        prod(0, 0, BL);
        prod_eos(0);
        prod_eos(1);
        prod_eos(2);
        exp_blk(0, 0, BL);
        expq.push_back(EOS);
        release_rst();
        wait_end(1'b0);

        // 2: two producers alternate whole blocks
        do_reset();
        prod(0, 0, 2 * BL);
        prod_eos(0);
        prod(1, 0, 2 * BL);
        prod_eos(1);
        prod_eos(2);
        exp_blk(0, 0, BL);
        exp_blk(1, 0, BL);
        exp_blk(0, BL, BL);
        exp_blk(1, BL, BL);
        expq.push_back(EOS);
        release_rst();
        wait_end(1'b0);

        // 3: back-pressure for 5 cycles at token 30
        do_reset();
        prod(0, 0, BL);
        prod_eos(0);
        prod_eos(1);
        prod_eos(2);
        exp_blk(0, 0, BL);
        expq.push_back(EOS);
        release_rst();
        wait_left(BL + 1 - 30);
        out_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("stall_out_v", 32'(out_v), 32'd1);
            check("stall_out_d", 32'(out_d), 32'(tok(0, 30)));
            check("stall_in_b0", 32'(in_b[0]), 32'd1);
            check("stall_q0", 32'(q0.size()), 32'(BL + 1 - 30));
        end
        @(posedge clock);
        #2;
        out_b = 1'b0;
        wait_end(1'b0);

        // 4: producer 1 eos mid-block
        do_reset();
        prod(0, 0, 2 * BL);
        prod_eos(0);
        prod(1, 0, 10);
        prod_eos(1);
        prod(1, 10, 1);
        prod_eos(2);
        exp_blk(0, 0, BL);
        exp_blk(1, 0, 10);
        exp_blk(0, BL, BL);
        expq.push_back(EOS);
        release_rst();
        wait_end(1'b1);
        check("p1_stalled", 32'(in_b[1]), 32'd1);
        check("p1_left", 32'(q1.size()), 32'd1);

        // 5: reset at token 40, then clean restart
        do_reset();
        prod(0, 0, BL);
        prod(1, 0, BL);
        exp_blk(0, 0, BL);
        release_rst();
        wait_left(BL - 40);
        do_reset();
        prod(0, 0, BL);
        prod_eos(0);
        prod(1, 0, BL);
        prod_eos(1);
        prod_eos(2);
        exp_blk(0, 0, BL);
        exp_blk(1, 0, BL);
        expq.push_back(EOS);
        release_rst();
        wait_end(1'b0);

        // 6: producer 1 retires first, 0 and 2 alternate
        do_reset();
        prod(0, 0, 2 * BL);
        prod_eos(0);
        prod_eos(1);
        prod(2, 0, 2 * BL);
        prod_eos(2);
        exp_blk(0, 0, BL);
        exp_blk(2, 0, BL);
        exp_blk(0, BL, BL);
        exp_blk(2, BL, BL);
        expq.push_back(EOS);
        release_rst();
        wait_end(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
